ifu_fetch_ctrl: RTL and testbench

//   Sequences instruction fetch for the pipelined core.
//   - Owns the fetch PC and issues requests to the instruction ROM over a req/ack handshake, so ROM latency may vary.
//   - Buffers fetched {pc, instr} pairs in a small queue toward decode, using a valid/ready handshake.
//   - Applies branch/jump redirects from decode: flushes the queue and discards any in-flight fetch.

---
 rtl/ifu_pkg.sv | 13 +
 rtl/ifu_fetch_queue.sv | 53 +++++
 rtl/ifu_fetch_ctrl.sv | 137 +++++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit.
package ifu_pkg;

    localparam logic [31:0] IFU_RESET_PC = 32'h0000_3000;

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DISCARD} fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fetch_queue.sv
// ifu_fetch_queue: circular FIFO of {pc, instr} entries with flush; head reads as zero when empty.
module ifu_fetch_queue
    import ifu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          RESET,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  din,
    output logic [CW-1:0] count,
    output fetch_entry_t  head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t   mem_q [DEPTH];
    logic [PW-1:0]  rd_q, wr_q;
    logic [CW-1:0]  count_q;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Pointer and occupancy bookkeeping; flush empties the queue outright.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_q <= nxt(wr_q);
            if (pop)  rd_q <= nxt(rd_q);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Entry storage needs no reset: the head is masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_q] <= din;
    end

    assign count = count_q;
    assign head  = (count_q != '0) ? mem_q[rd_q] : '0;

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: fetch PC sequencing, ROM req/ack handshake, redirect handling and decode queue.
// Optional perf counters are built when FETCH_PERF_EN is defined.
module ifu_fetch_ctrl
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = IFU_RESET_PC,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        RESET,
    output logic        rom_req,
    output logic [31:0] rom_addr,
    input  logic        rom_ack,
    input  logic [31:0] rom_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    input  logic        id_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_starve_cnt
`endif
);

    localparam int CW = $clog2(QUEUE_DEPTH + 1);

    fetch_state_t  state_q;
    logic [31:0]   fetch_pc_q;
    logic [31:0]   pend_pc_q;
    logic          rom_req_q;
    logic [31:0]   tgt_pc;
    logic          ack, push, pop, space_next;
    logic [CW-1:0] q_count;
    logic [CW:0]   cnt_after;
    fetch_entry_t  head;

    assign tgt_pc     = {redirect_pc[31:2], 2'b00};
    assign ack        = rom_req_q & rom_ack;
    assign push       = (state_q == REQ) & ack & ~redirect;
    assign pop        = id_valid & id_ready;
    assign cnt_after  = redirect ? '0 : {1'b0, q_count} + (CW+1)'(push) - (CW+1)'(pop);
    assign space_next = cnt_after < (CW+1)'(QUEUE_DEPTH);

    // Fetch FSM; a redirect that arrives mid-handshake is parked in pend_pc_q so the
    // ROM address stays stable until the outstanding request is acknowledged.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            pend_pc_q  <= RESET_PC;
            rom_req_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (redirect) fetch_pc_q <= tgt_pc;
                    state_q   <= REQ;
                    rom_req_q <= 1'b1;
                end
                REQ: begin
                    if (redirect) begin
                        if (ack) begin
                            fetch_pc_q <= tgt_pc;
                        end else begin
                            pend_pc_q <= tgt_pc;
                            state_q   <= DISCARD;
                        end
                    end else if (ack) begin
                        fetch_pc_q <= fetch_pc_q + 32'd4;
                        state_q    <= space_next ? REQ : HOLD;
                        rom_req_q  <= space_next;
                    end
                end
                HOLD: begin
                    if (redirect) fetch_pc_q <= tgt_pc;
                    if (redirect || space_next) begin
                        state_q   <= REQ;
                        rom_req_q <= 1'b1;
                    end
                end
                DISCARD: begin
                    if (ack) begin
                        fetch_pc_q <= redirect ? tgt_pc : pend_pc_q;
                        state_q    <= REQ;
                    end else if (redirect) begin
                        pend_pc_q <= tgt_pc;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    rom_req_q <= 1'b0;
                end
            endcase
        end
    end

    ifu_fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .CW    (CW)
    ) u_queue (
        .clk   (clk),
        .RESET (RESET),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   ('{pc: fetch_pc_q, instr: rom_rdata}),
        .count (q_count),
        .head  (head)
    );

    assign rom_req  = rom_req_q;
    assign rom_addr = fetch_pc_q;
    assign id_valid = q_count != '0;
    assign id_pc    = head.pc;
    assign id_instr = head.instr;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_starve_q;

    // Delivered-instruction and decode-starvation counters; redirects leave them alone.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            perf_fetch_q  <= '0;
            perf_starve_q <= '0;
        end else begin
            perf_fetch_q  <= perf_fetch_q + 32'(pop);
            perf_starve_q <= perf_starve_q + 32'(id_ready & ~id_valid);
        end
    end

    assign perf_fetch_cnt  = perf_fetch_q;
    assign perf_starve_cnt = perf_starve_q;
`endif

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// tb_ifu_fetch_ctrl: directed scenarios plus randomized ROM latency/backpressure/redirects against a stream model.
module tb_ifu_fetch_ctrl;

    logic        clk = 1'b0;
    logic        RESET = 1'b1;
    logic        rom_req;
    logic [31:0] rom_addr;
    logic        rom_ack = 1'b0;
    logic [31:0] rom_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready = 1'b0;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_starve_cnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ifu_fetch_ctrl dut (
        .clk             (clk),
        .RESET           (RESET),
        .rom_req         (rom_req),
        .rom_addr        (rom_addr),
        .rom_ack         (rom_ack),
        .rom_rdata       (rom_rdata),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .id_valid        (id_valid),
        .id_instr        (id_instr),
        .id_pc           (id_pc),
        .id_ready        (id_ready)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_starve_cnt (perf_starve_cnt)
`endif
    );

    function automatic logic [31:0] romfun(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        RESET = 1'b0;
        rom_ack = 1'b0;
        redirect = 1'b0;
        id_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        RESET = 1'b1;
        step();
    endtask

    task automatic test_reset;
        RESET = 1'b0;
        @(negedge clk);
        checks++;
        if (rom_req !== 1'b0 || rom_addr !== 32'h3000 || id_valid !== 1'b0 || id_pc !== 32'h0 || id_instr !== 32'h0) begin
            failures++;
            $display("FAIL reset_values: req=%b addr=%h valid=%b pc=%h instr=%h, want 0/00003000/0/0/0", rom_req, rom_addr, id_valid, id_pc, id_instr);
        end
        RESET = 1'b1;
        #1;
        checks++;
        if (rom_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: req=%b want 0", rom_req);
        end
        step();
        checks++;
        if (rom_req !== 1'b1 || rom_addr !== 32'h3000) begin
            failures++;
            $display("FAIL reset_first_req: req=%b addr=%h want 1/00003000", rom_req, rom_addr);
        end
    endtask

    task automatic test_stream;
        logic [31:0] e;
        do_reset();
        id_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (rom_req !== 1'b1 || rom_addr !== 32'h3000 + 32'(4 * k)) begin
                failures++;
                $display("FAIL stream_addr[%0d]: req=%b addr=%h want 1/%h", k, rom_req, rom_addr, 32'h3000 + 32'(4 * k));
            end
            e = 32'h3000 + 32'(4 * (k - 1));
            checks++;
            if (k == 0 ? (id_valid !== 1'b0) : (id_valid !== 1'b1 || id_pc !== e || id_instr !== romfun(e))) begin
                failures++;
                $display("FAIL stream_id[%0d]: valid=%b pc=%h instr=%h want valid=%0d pc=%h", k, id_valid, id_pc, id_instr, k > 0, e);
            end
            rom_ack = 1'b1;
            rom_rdata = romfun(rom_addr);
            step();
        end
        rom_ack = 1'b0;
    endtask

    task automatic test_backpressure;
        int acc;
        logic [31:0] e;
        do_reset();
        acc = 0;
        for (int n = 0; n < 6; n++) begin
            rom_ack = rom_req;
            rom_rdata = romfun(rom_addr);
            if (rom_req) acc++;
            step();
        end
        checks++;
        if (acc != 2 || rom_req !== 1'b0 || id_valid !== 1'b1 || id_pc !== 32'h3000) begin
            failures++;
            $display("FAIL bp_hold: acks=%0d req=%b valid=%b pc=%h want 2/0/1/00003000", acc, rom_req, id_valid, id_pc);
        end
        id_ready = 1'b1;
        e = 32'h3000;
        for (int n = 0; n < 6; n++) begin
            if (n == 1) begin
                checks++;
                if (rom_req !== 1'b1 || rom_addr !== 32'h3008) begin
                    failures++;
                    $display("FAIL bp_resume: req=%b addr=%h want 1/00003008", rom_req, rom_addr);
                end
            end
            checks++;
            if (id_valid !== 1'b1 || id_pc !== e || id_instr !== romfun(e)) begin
                failures++;
                $display("FAIL bp_drain[%0d]: valid=%b pc=%h instr=%h want 1/%h", n, id_valid, id_pc, id_instr, e);
            end
            e += 4;
            rom_ack = rom_req;
            rom_rdata = romfun(rom_addr);
            step();
        end
        rom_ack = 1'b0;
        id_ready = 1'b0;
    endtask

    task automatic test_redirect_wait;
        do_reset();
        id_ready = 1'b1;
        step();
        redirect = 1'b1;
        redirect_pc = 32'h3100;
        step();
        redirect = 1'b0;
        for (int n = 0; n < 2; n++) begin
            checks++;
            if (rom_req !== 1'b1 || rom_addr !== 32'h3000) begin
                failures++;
                $display("FAIL rw_hold[%0d]: req=%b addr=%h want 1/00003000", n, rom_req, rom_addr);
            end
            if (n == 1) begin
                rom_ack = 1'b1;
                rom_rdata = romfun(32'h3000);
            end
            step();
        end
        checks++;
        if (rom_req !== 1'b1 || rom_addr !== 32'h3100 || id_valid !== 1'b0) begin
            failures++;
            $display("FAIL rw_new_addr: req=%b addr=%h valid=%b want 1/00003100/0", rom_req, rom_addr, id_valid);
        end
        rom_rdata = romfun(32'h3100);
        step();
        rom_ack = 1'b0;
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h3100 || id_instr !== romfun(32'h3100)) begin
            failures++;
            $display("FAIL rw_first_id: valid=%b pc=%h instr=%h want 1/00003100/%h", id_valid, id_pc, id_instr, romfun(32'h3100));
        end
        id_ready = 1'b0;
    endtask

    task automatic test_redirect_ack_pop;
        do_reset();
        rom_ack = 1'b1;
        rom_rdata = romfun(rom_addr);
        step();
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h3000) begin
            failures++;
            $display("FAIL rap_pre: valid=%b pc=%h want 1/00003000", id_valid, id_pc);
        end
        rom_rdata = romfun(rom_addr);
        id_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h3203;
        step();
        redirect = 1'b0;
        checks++;
        if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_instr !== 32'h0 || rom_req !== 1'b1 || rom_addr !== 32'h3200) begin
            failures++;
            $display("FAIL rap_flush: valid=%b pc=%h instr=%h req=%b addr=%h want 0/0/0/1/00003200", id_valid, id_pc, id_instr, rom_req, rom_addr);
        end
        rom_rdata = romfun(rom_addr);
        step();
        rom_ack = 1'b0;
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h3200 || id_instr !== romfun(32'h3200)) begin
            failures++;
            $display("FAIL rap_next: valid=%b pc=%h instr=%h want 1/00003200", id_valid, id_pc, id_instr);
        end
        id_ready = 1'b0;
    endtask

    task automatic test_wrap;
        do_reset();
        id_ready = 1'b1;
        rom_ack = 1'b1;
        rom_rdata = romfun(rom_addr);
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        checks++;
        if (rom_addr !== 32'hFFFF_FFFC || id_valid !== 1'b0) begin
            failures++;
            $display("FAIL wrap_first: addr=%h valid=%b want fffffffc/0", rom_addr, id_valid);
        end
        rom_rdata = romfun(rom_addr);
        step();
        checks++;
        if (rom_addr !== 32'h0 || id_valid !== 1'b1 || id_pc !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL wrap_zero: addr=%h valid=%b pc=%h want 00000000/1/fffffffc", rom_addr, id_valid, id_pc);
        end
        rom_rdata = romfun(rom_addr);
        step();
        checks++;
        if (rom_addr !== 32'h4 || id_pc !== 32'h0 || id_instr !== romfun(32'h0)) begin
            failures++;
            $display("FAIL wrap_next: addr=%h pc=%h instr=%h want 00000004/00000000/%h", rom_addr, id_pc, id_instr, romfun(32'h0));
        end
        rom_ack = 1'b0;
        id_ready = 1'b0;
    endtask

    task automatic test_async_reset;
        do_reset();
        rom_ack = 1'b1;
        rom_rdata = romfun(rom_addr);
        step();
        rom_ack = 1'b0;
        checks++;
        if (id_valid !== 1'b1 || rom_req !== 1'b1 || rom_addr !== 32'h3004) begin
            failures++;
            $display("FAIL ar_pre: valid=%b req=%b addr=%h want 1/1/00003004", id_valid, rom_req, rom_addr);
        end
        @(posedge clk);
        #2;
        RESET = 1'b0;
        #1;
        checks++;
        if (rom_req !== 1'b0 || id_valid !== 1'b0 || rom_addr !== 32'h3000 || id_pc !== 32'h0) begin
            failures++;
            $display("FAIL ar_immediate: req=%b valid=%b addr=%h pc=%h want 0/0/00003000/0", rom_req, id_valid, rom_addr, id_pc);
        end
        @(negedge clk);
        rom_ack = 1'b1;
        rom_rdata = 32'hDEAD_BEEF;
        step();
        checks++;
        if (rom_req !== 1'b0 || id_valid !== 1'b0) begin
            failures++;
            $display("FAIL ar_ack_ignored: req=%b valid=%b want 0/0", rom_req, id_valid);
        end
        rom_ack = 1'b0;
        RESET = 1'b1;
        step();
        checks++;
        if (rom_req !== 1'b1 || rom_addr !== 32'h3000 || id_valid !== 1'b0) begin
            failures++;
            $display("FAIL ar_restart: req=%b addr=%h valid=%b want 1/00003000/0", rom_req, rom_addr, id_valid);
        end
        rom_ack = 1'b1;
        rom_rdata = romfun(rom_addr);
        id_ready = 1'b1;
        step();
        rom_ack = 1'b0;
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h3000 || id_instr !== romfun(32'h3000)) begin
            failures++;
            $display("FAIL ar_first_id: valid=%b pc=%h instr=%h want 1/00003000", id_valid, id_pc, id_instr);
        end
        id_ready = 1'b0;
    endtask

    task automatic test_random;
        logic [31:0] exp_pc, prev_addr;
        logic        prev_pend;
        int          wait_cnt, pops;
        do_reset();
        exp_pc = 32'h3000;
        prev_pend = 1'b0;
        prev_addr = '0;
        wait_cnt = $urandom_range(0, 3);
        pops = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!id_valid) begin
                checks++;
                if (id_pc !== 32'h0 || id_instr !== 32'h0) begin
                    failures++;
                    $display("FAIL rnd_empty_zero[%0d]: pc=%h instr=%h want 0/0", cyc, id_pc, id_instr);
                end
            end
            if (prev_pend) begin
                checks++;
                if (rom_req !== 1'b1 || rom_addr !== prev_addr) begin
                    failures++;
                    $display("FAIL rnd_addr_hold[%0d]: req=%b addr=%h want 1/%h", cyc, rom_req, rom_addr, prev_addr);
                end
            end
            id_ready = ($urandom % 4) != 0;
            redirect = ($urandom % 16) == 0;
            redirect_pc = $urandom;
            if (rom_req) begin
                rom_ack = wait_cnt == 0;
                rom_rdata = rom_ack ? romfun(rom_addr) : $urandom;
            end else begin
                rom_ack = $urandom % 2;
                rom_rdata = $urandom;
            end
            if (id_valid && id_ready) begin
                checks++;
                if (id_pc !== exp_pc || id_instr !== romfun(exp_pc)) begin
                    failures++;
                    $display("FAIL rnd_pop[%0d]: pc=%h instr=%h want %h/%h", cyc, id_pc, id_instr, exp_pc, romfun(exp_pc));
                end
                exp_pc += 4;
                pops++;
            end
            if (redirect) exp_pc = {redirect_pc[31:2], 2'b00};
            prev_pend = rom_req && !rom_ack;
            prev_addr = rom_addr;
            if (rom_req) wait_cnt = rom_ack ? int'($urandom_range(0, 3)) : wait_cnt - 1;
            step();
        end
        rom_ack = 1'b0;
        redirect = 1'b0;
        id_ready = 1'b0;
        checks++;
        if (pops < 200) begin
            failures++;
            $display("FAIL rnd_progress: pops=%0d want >=200", pops);
        end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf;
        do_reset();
        checks++;
        if (perf_fetch_cnt !== 32'd0 || perf_starve_cnt !== 32'd0) begin
            failures++;
            $display("FAIL perf_reset: fetch=%0d starve=%0d want 0/0", perf_fetch_cnt, perf_starve_cnt);
        end
        id_ready = 1'b1;
        repeat (3) step();
        id_ready = 1'b0;
        rom_ack = 1'b1;
        rom_rdata = romfun(rom_addr);
        step();
        id_ready = 1'b1;
        repeat (10) begin
            rom_rdata = romfun(rom_addr);
            step();
        end
        id_ready = 1'b0;
        rom_ack = 1'b0;
        checks++;
        if (perf_fetch_cnt !== 32'd10 || perf_starve_cnt !== 32'd3) begin
            failures++;
            $display("FAIL perf_counts: fetch=%0d starve=%0d want 10/3", perf_fetch_cnt, perf_starve_cnt);
        end
        do_reset();
        checks++;
        if (perf_fetch_cnt !== 32'd0 || perf_starve_cnt !== 32'd0) begin
            failures++;
            $display("FAIL perf_after_reset: fetch=%0d starve=%0d want 0/0", perf_fetch_cnt, perf_starve_cnt);
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RESET = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_ack_pop();
        test_wrap();
        test_async_reset();
        test_random();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
